// File: rtl/issue_ctrl_pipe_pkg.sv
// Shared opcode constants, ALU operation encoding and slot decode record
// for the registered issue-control pipeline.
package issue_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_XOR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_CLR  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_MULI = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_CMPE = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_CMPG = 5'b10011;
    localparam logic [OPC_W-1:0] OPC_CMPL = 5'b10100;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b10101;
    localparam logic [OPC_W-1:0] OPC_SHRL = 5'b10110;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b10111;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_CLR  = 4'd6,
        ALU_CMPE = 4'd7,
        ALU_CMPG = 4'd8,
        ALU_CMPL = 4'd9,
        ALU_SHRA = 4'd10,
        ALU_SHRL = 4'd11,
        ALU_SHL  = 4'd12,
        ALU_NOP  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        SLOT_ALU = 2'd0,
        SLOT_MUL = 2'd1,
        SLOT_LS  = 2'd2
    } slot_kind_e;

    typedef struct packed {
        alu_op_t alu_op;
        logic    imm_sel;
        logic    mul_en;
        logic    mul_imm;
        logic    ld;
        logic    st;
        logic    illegal;
    } dec_t;

    function automatic logic is_mul_opc(input logic [OPC_W-1:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_MULI);
    endfunction

endpackage

// File: rtl/issue_ctrl_pipe_if.sv
// Issue-side and execute-side handshake bundle of issue_ctrl_pipe.
interface issue_ctrl_pipe_if #(
    parameter int NUM_ALU = 2,
    parameter int OP_W    = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_ALU*OP_W-1:0]   alu_opc;
    logic [OP_W-1:0]           mul_opc;
    logic [OP_W-1:0]           ls_opc;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_ALU*4-1:0]      alu_op;
    logic [NUM_ALU-1:0]        alu_imm_sel;
    logic                      mul_en;
    logic                      mul_imm_sel;
    logic                      ld_en;
    logic                      st_en;
    logic [NUM_ALU+1:0]        err_slot;
    logic                      err_sticky;
    logic                      err_clr;
    logic                      mul_busy;

    modport master (
        output in_valid, alu_opc, mul_opc, ls_opc, out_ready, err_clr,
        input  in_ready, out_valid, alu_op, alu_imm_sel, mul_en, mul_imm_sel,
               ld_en, st_en, err_slot, err_sticky, mul_busy
    );

    modport slave (
        input  in_valid, alu_opc, mul_opc, ls_opc, out_ready, err_clr,
        output in_ready, out_valid, alu_op, alu_imm_sel, mul_en, mul_imm_sel,
               ld_en, st_en, err_slot, err_sticky, mul_busy
    );
endinterface

// File: rtl/issue_ctrl_pipe_slot_decode.sv
// Combinational decode of one slot opcode; KIND restricts which opcodes
// are legal in the slot, everything else is squashed to NOP and flagged.
module slot_decode
    import issue_pkg::*;
#(
    parameter slot_kind_e KIND = SLOT_ALU,
    parameter int         OP_W = 5
) (
    input  logic [OP_W-1:0] opc,
    output dec_t            dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_NOP;
        case (KIND)
            SLOT_ALU: begin
                case (opc)
                    OPC_ADD:  dec.alu_op = ALU_ADD;
                    OPC_ADDI: begin dec.alu_op = ALU_ADD; dec.imm_sel = 1'b1; end
                    OPC_SUB:  dec.alu_op = ALU_SUB;
                    OPC_SUBI: begin dec.alu_op = ALU_SUB; dec.imm_sel = 1'b1; end
                    OPC_AND:  dec.alu_op = ALU_AND;
                    OPC_OR:   dec.alu_op = ALU_OR;
                    OPC_XOR:  dec.alu_op = ALU_XOR;
                    OPC_NOT:  dec.alu_op = ALU_NOT;
                    OPC_CLR:  dec.alu_op = ALU_CLR;
                    OPC_CMPE: dec.alu_op = ALU_CMPE;
                    OPC_CMPG: dec.alu_op = ALU_CMPG;
                    OPC_CMPL: dec.alu_op = ALU_CMPL;
                    OPC_SHRA: dec.alu_op = ALU_SHRA;
                    OPC_SHRL: dec.alu_op = ALU_SHRL;
                    OPC_SHL:  dec.alu_op = ALU_SHL;
                    OPC_NOP:  dec.alu_op = ALU_NOP;
                    default:  dec.illegal = 1'b1;
                endcase
            end
            SLOT_MUL: begin
                case (opc)
                    OPC_MUL:  dec.mul_en = 1'b1;
                    OPC_MULI: begin dec.mul_en = 1'b1; dec.mul_imm = 1'b1; end
                    OPC_NOP:  dec.mul_en = 1'b0;
                    default:  dec.illegal = 1'b1;
                endcase
            end
            SLOT_LS: begin
                case (opc)
                    OPC_LD:   dec.ld = 1'b1;
                    OPC_ST:   dec.st = 1'b1;
                    OPC_NOP:  dec.ld = 1'b0;
                    default:  dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/issue_ctrl_pipe.sv
// Issue bundle decoder with a one-deep valid/ready output register,
// multiplier occupancy tracking and a sticky illegal-opcode flag.
module issue_ctrl_pipe
    import issue_pkg::*;
#(
    parameter int NUM_ALU = 2,
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    issue_ctrl_pipe_if.slave bus
);

    localparam int NSLOT  = NUM_ALU + 2;
    localparam int MUL_IX = NUM_ALU;
    localparam int LS_IX  = NUM_ALU + 1;
    localparam int CNT_W  = $clog2(MUL_LAT) + 1;

    logic [NSLOT-1:0][OP_W-1:0] slot_opc;
    dec_t [NSLOT-1:0]           dec;
    logic [NSLOT-1:0]           err_next;

    logic [NUM_ALU-1:0][3:0]    alu_op_q;
    logic [NUM_ALU-1:0]         imm_q;
    logic                       out_valid_q, mul_en_q, mul_imm_q, ld_q, st_q;
    logic [NSLOT-1:0]           err_q;
    logic                       sticky_q;
    logic [CNT_W-1:0]           mul_cnt;
    logic                       mul_busy, in_ready, accept;

    // One decoder per slot: ALU lanes, then the multiplier and load/store slots.
    for (genvar g = 0; g < NUM_ALU; g++) begin : g_alu
        assign slot_opc[g] = bus.alu_opc[g*OP_W +: OP_W];
        slot_decode #(.KIND(SLOT_ALU), .OP_W(OP_W)) u_dec (.opc(slot_opc[g]), .dec(dec[g]));
    end
    assign slot_opc[MUL_IX] = bus.mul_opc;
    assign slot_opc[LS_IX]  = bus.ls_opc;
    slot_decode #(.KIND(SLOT_MUL), .OP_W(OP_W)) u_dec_mul (.opc(slot_opc[MUL_IX]), .dec(dec[MUL_IX]));
    slot_decode #(.KIND(SLOT_LS),  .OP_W(OP_W)) u_dec_ls  (.opc(slot_opc[LS_IX]),  .dec(dec[LS_IX]));

    logic unused_dec;
    assign unused_dec = ^dec;

    always_comb begin
        for (int i = 0; i < NSLOT; i++) err_next[i] = dec[i].illegal;
    end

    // Only a bundle that actually issues a multiply waits for the multiplier.
    assign mul_busy = (mul_cnt != '0);
    assign in_ready = (!out_valid_q || bus.out_ready) && !(mul_busy && is_mul_opc(bus.mul_opc));
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= '1;
            imm_q       <= '0;
            mul_en_q    <= 1'b0;
            mul_imm_q   <= 1'b0;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            err_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            for (int i = 0; i < NUM_ALU; i++) begin
                alu_op_q[i] <= dec[i].alu_op;
                imm_q[i]    <= dec[i].imm_sel;
            end
            mul_en_q    <= dec[MUL_IX].mul_en;
            mul_imm_q   <= dec[MUL_IX].mul_imm;
            ld_q        <= dec[LS_IX].ld;
            st_q        <= dec[LS_IX].st;
            err_q       <= err_next;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            mul_cnt <= '0;
        else if (accept && dec[MUL_IX].mul_en)
            mul_cnt <= CNT_W'(MUL_LAT - 1);
        else if (mul_busy)
            mul_cnt <= mul_cnt - CNT_W'(1);
    end

    // A new error outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            sticky_q <= 1'b0;
        else if (accept && (|err_next))
            sticky_q <= 1'b1;
        else if (bus.err_clr)
            sticky_q <= 1'b0;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_imm_sel = imm_q;
    assign bus.mul_en      = mul_en_q;
    assign bus.mul_imm_sel = mul_imm_q;
    assign bus.ld_en       = ld_q;
    assign bus.st_en       = st_q;
    assign bus.err_slot    = err_q;
    assign bus.err_sticky  = sticky_q;
    assign bus.mul_busy    = mul_busy;

endmodule
